// File: rtl/vdc_snd_pkg.sv
// Shared constants for the VDC-style sound generator: register map, CTRL
// bit positions, LFSR polynomial and pattern length.
package vdc_snd_pkg;

    localparam logic [1:0] A_SR_HI  = 2'd0;
    localparam logic [1:0] A_SR_MID = 2'd1;
    localparam logic [1:0] A_SR_LO  = 2'd2;
    localparam logic [1:0] A_CTRL   = 2'd3;

    localparam int CTRL_EN    = 7;
    localparam int CTRL_LOOP  = 6;
    localparam int CTRL_FREQ  = 5;
    localparam int CTRL_NOISE = 4;
    localparam int CTRL_VOL_H = 3;
    localparam int CTRL_VOL_L = 0;

    // Right-shifting Fibonacci LFSR, taps 16,14,13,11 map to bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS = 16'h002D;
    localparam logic [15:0] LFSR_SEED = 16'h0001;

    localparam logic [4:0] PAT_LEN  = 5'd24;
    localparam logic [4:0] PAT_LAST = PAT_LEN - 5'd1;

    function automatic logic lfsr_fb(input logic [15:0] state);
        return ^(state & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/vdc_snd_lfsr.sv
// 16-bit noise LFSR; advances once per processed sound tick and exposes bit 0.
module vdc_snd_lfsr
    import vdc_snd_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    input  logic step,
    output logic bit0
);

    logic [15:0] lfsr_r;

    // LFSR state register; seeded non-zero so the all-zero lockup state is never entered
    always_ff @(posedge Clk) begin
        if (Reset) begin
            lfsr_r <= LFSR_SEED;
        end else if (step) begin
            lfsr_r <= {lfsr_fb(lfsr_r), lfsr_r[15:1]};
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign bit0 = lfsr_r[0];

endmodule

// File: rtl/vdc_sound_gen.sv
// VideoPac VDC-style sound generator: 24-bit pattern shifter with optional
// noise mix, volume gate, tick prescaler and end-of-pattern IRQ.
module vdc_sound_gen
    import vdc_snd_pkg::*;
#(
    parameter int DIV_FAST = 12800,
    parameter int DIV_SLOW = 51200,
    parameter int PW       = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic [3:0] snd_out,
    output logic       snd_irq,
    output logic       busy
);

    logic [23:0]   sr_r,      sr_n;
    logic [7:0]    ctrl_r,    ctrl_n;
    logic [PW-1:0] presc_r,   presc_n;
    logic [4:0]    bitcnt_r,  bitcnt_n;
    logic          tick_pend_r, tick_pend_n;
    logic [3:0]    snd_out_r, snd_out_n;
    logic          snd_irq_r, snd_irq_n;

    logic          en_s;
    logic          tick_s;
    logic          tick_due_s;
    logic          proc_s;
    logic          lfsr_bit_s;
    logic          pat_bit_s;
    logic [PW-1:0] reload_s;

    assign en_s       = ctrl_r[CTRL_EN];
    assign tick_s     = en_s && (presc_r == {PW{1'b0}});
    assign tick_due_s = tick_s | tick_pend_r;
    // A write always wins the cycle; any due tick is deferred to the next one
    assign proc_s     = tick_due_s & ~wr_en & en_s;
    assign pat_bit_s  = sr_r[0] ^ (ctrl_r[CTRL_NOISE] & lfsr_bit_s);
    assign reload_s   = ctrl_r[CTRL_FREQ] ? PW'(DIV_FAST - 1) : PW'(DIV_SLOW - 1);

    vdc_snd_lfsr u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .step  (proc_s),
        .bit0  (lfsr_bit_s)
    );

    // Next-state logic: prescaler, register writes, tick processing
    always_comb begin
        sr_n        = sr_r;
        ctrl_n      = ctrl_r;
        bitcnt_n    = bitcnt_r;
        tick_pend_n = tick_pend_r;
        snd_out_n   = snd_out_r;
        snd_irq_n   = 1'b0;

        if (!en_s) begin
            presc_n = {PW{1'b0}};
        end else if (tick_s) begin
            presc_n = reload_s;
        end else begin
            presc_n = presc_r - PW'(1);
        end

        if (wr_en) begin
            case (wr_addr)
                A_SR_HI:  sr_n[23:16] = wr_data;
                A_SR_MID: sr_n[15:8]  = wr_data;
                A_SR_LO:  sr_n[7:0]   = wr_data;
                A_CTRL: begin
                    ctrl_n = wr_data;
                    if (!wr_data[CTRL_EN]) begin
                        snd_out_n = 4'h0;
                        presc_n   = {PW{1'b0}};
                    end else if (!en_s) begin
                        // Restart: first tick lands on the very next cycle
                        bitcnt_n = 5'd0;
                        presc_n  = {PW{1'b0}};
                    end else begin
                        bitcnt_n = bitcnt_r;
                    end
                end
                default: sr_n = sr_r;
            endcase
            tick_pend_n = tick_due_s & ctrl_n[CTRL_EN];
        end else if (proc_s) begin
            tick_pend_n = 1'b0;
            snd_out_n   = pat_bit_s ? ctrl_r[CTRL_VOL_H:CTRL_VOL_L] : 4'h0;
            sr_n        = {(ctrl_r[CTRL_LOOP] ? sr_r[0] : 1'b0), sr_r[23:1]};
            if (bitcnt_r == PAT_LAST) begin
                bitcnt_n  = 5'd0;
                snd_irq_n = 1'b1;
                if (!ctrl_r[CTRL_LOOP]) begin
                    ctrl_n[CTRL_EN] = 1'b0;
                end else begin
                    ctrl_n[CTRL_EN] = 1'b1;
                end
            end else begin
                bitcnt_n = bitcnt_r + 5'd1;
            end
        end else if (!en_s) begin
            tick_pend_n = 1'b0;
            snd_out_n   = 4'h0;
        end else begin
            tick_pend_n = tick_pend_r;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sr_r        <= 24'h000000;
            ctrl_r      <= 8'h00;
            presc_r     <= {PW{1'b0}};
            bitcnt_r    <= 5'd0;
            tick_pend_r <= 1'b0;
            snd_out_r   <= 4'h0;
            snd_irq_r   <= 1'b0;
        end else begin
            sr_r        <= sr_n;
            ctrl_r      <= ctrl_n;
            presc_r     <= presc_n;
            bitcnt_r    <= bitcnt_n;
            tick_pend_r <= tick_pend_n;
            snd_out_r   <= snd_out_n;
            snd_irq_r   <= snd_irq_n;
        end
    end

    assign snd_out = snd_out_r;
    assign snd_irq = snd_irq_r;
    assign busy    = ctrl_r[CTRL_EN];

endmodule

// File: tb/tb_vdc_sound_gen.sv
// Self-checking bench for vdc_sound_gen: directed scenarios plus randomized
// patterns compared cycle by cycle against a pattern/tick-schedule model.
module tb_vdc_sound_gen;
    import vdc_snd_pkg::*;

    logic       Clk;
    logic       Reset;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] snd_out;
    logic       snd_irq;
    logic       busy;

    int n_tests;
    int n_fail;

    vdc_sound_gen #(.DIV_FAST(4), .DIV_SLOW(16), .PW(16)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .snd_out (snd_out),
        .snd_irq (snd_irq),
        .busy    (busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // All tasks are entered on a falling edge and return on a falling edge
    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge Clk);
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic load_sr(input logic [23:0] p);
        wr(A_SR_HI,  p[23:16]);
        wr(A_SR_MID, p[15:8]);
        wr(A_SR_LO,  p[7:0]);
    endtask

    // Golden noise sequence: right-shift Fibonacci, taps 16,14,13,11, seed 1
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic [15:0] fb;
        fb = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'h0001;
        return (s >> 1) | (fb << 15);
    endfunction

    function automatic int tcyc(input int k, input int per, input int m);
        return per * k + ((k == m) ? 1 : 0);
    endfunction

    // Reset, load pattern p, enable with ctrl and check every cycle for ncyc cycles.
    // If m >= 0, SR_LO is rewritten with b exactly on the cycle of tick m.
    task automatic run(input string tag, input logic [23:0] p, input logic [7:0] ctrl,
                       input int ncyc, input int m, input logic [7:0] b);
        logic        nz [0:1023];
        logic [15:0] s;
        logic [47:0] pp;
        logic [23:0] pn;
        logic        loop_b, noise_b, sb;
        logic [3:0]  vol, exp_snd;
        logic        exp_irq;
        int          per, next_k;

        loop_b  = ctrl[6];
        noise_b = ctrl[4];
        vol     = ctrl[3:0];
        per     = ctrl[5] ? 4 : 16;
        s = 16'h0001;
        for (int k = 0; k < 1024; k++) begin
            nz[k] = s[0];
            s = lfsr_next(s);
        end
        pp = {p, p};
        pp = pp >> ((m > 0) ? m : 0);
        pn = {pp[23:8], b};

        do_reset();
        load_sr(p);
        wr(A_CTRL, ctrl);
        next_k  = 0;
        exp_snd = 4'h0;
        for (int c = 0; c < ncyc; c++) begin
            if (m >= 0 && c == m * per) begin
                wr_en   = 1'b1;
                wr_addr = A_SR_LO;
                wr_data = b;
            end
            @(negedge Clk);
            wr_en   = 1'b0;
            exp_irq = 1'b0;
            if ((loop_b || next_k < 24) && c == tcyc(next_k, per, m)) begin
                if (m >= 0 && next_k >= m) sb = pn[(next_k - m) % 24];
                else                       sb = p[next_k % 24];
                sb      = sb ^ (noise_b & nz[next_k]);
                exp_snd = sb ? vol : 4'h0;
                exp_irq = (next_k % 24 == 23);
                next_k++;
            end else if (!loop_b && next_k >= 24) begin
                exp_snd = 4'h0;
            end
            chk({tag, "_snd"}, 32'(snd_out), 32'(exp_snd));
            chk({tag, "_irq"}, 32'(snd_irq), 32'(exp_irq));
            if (loop_b || c < tcyc(23, per, m))
                chk({tag, "_busy"}, 32'(busy), 32'd1);
            else if (c > tcyc(23, per, m))
                chk({tag, "_busy"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        logic [23:0] rp;
        logic [7:0]  rc;
        int          rm;
        n_tests = 0;
        n_fail  = 0;
        Reset   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = 2'd0;
        wr_data = 8'h00;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        chk("rst_snd", 32'(snd_out), 32'd0);
        chk("rst_irq", 32'(snd_irq), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Reset mid-pattern while running
        load_sr(24'hFFFFFF);
        wr(A_CTRL, 8'hEF);
        repeat (9) @(negedge Clk);
        chk("t1_pre_snd", 32'(snd_out), 32'hF);
        chk("t1_pre_busy", 32'(busy), 32'd1);
        do_reset();
        chk("t1_snd", 32'(snd_out), 32'd0);
        chk("t1_irq", 32'(snd_irq), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            chk("t1_idle", 32'({busy, snd_irq, snd_out}), 32'd0);
        end

        run("t2", 24'hAAAAAA, 8'hEF, 48 * 4, -1, 8'h00);
        run("t3", 24'h000001, 8'hA8, 23 * 4 + 12, -1, 8'h00);
        run("t4", 24'h800001, 8'hEF, 72 * 4, -1, 8'h00);
        run("t5", 24'h000000, 8'hFF, 64 * 4, -1, 8'h00);
        run("t6", 24'h123456, 8'hEF, 30 * 4, 5, 8'h5A);

        // Disable mid-run, then re-enable: SR retained, restart is prompt
        do_reset();
        load_sr(24'hFFFFFF);
        wr(A_CTRL, 8'hEF);
        repeat (6) @(negedge Clk);
        wr(A_CTRL, 8'h6F);
        chk("dis_snd", 32'(snd_out), 32'd0);
        chk("dis_busy", 32'(busy), 32'd0);
        wr(A_CTRL, 8'hEF);
        @(negedge Clk);
        chk("reen_snd", 32'(snd_out), 32'hF);

        for (int i = 0; i < 6; i++) begin
            rp = 24'($urandom);
            rc = {1'b1, 3'($urandom_range(0, 7)), 4'($urandom_range(1, 15))};
            rm = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 20) : -1;
            run("rnd", rp, rc, rc[6] ? 30 * (rc[5] ? 4 : 16) : 23 * (rc[5] ? 4 : 16) + 12,
                rm, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
